// File: rtl/lane_hit_reader.sv
`default_nettype none
// ============================================================================
//  Module      : lane_hit_reader
//  Description : Scans one lane's hit zone in the framebuffer through a
//                synchronous-read port. It counts the pixels that match the
//                tile colour and reports hit/miss over a go/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_hit_reader #(
    parameter int         ZONE_Y0     = 200,
    parameter int         ZONE_Y1     = 239,
    parameter logic [2:0] TILE_COLOUR = 3'b000,
    parameter int         HIT_THRESH  = 400
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       check_go,
    input  logic [2:0] line_id,
    output logic       rd_en,
    output logic [8:0] x,
    output logic [7:0] y,
    input  logic [2:0] rd_data,
    output logic       check_done,
    output logic       hit,
    output logic [9:0] pixel_count
);

    localparam logic [7:0]  c_Y0        = 8'(ZONE_Y0);
    localparam logic [7:0]  c_Y1        = 8'(ZONE_Y1);
    localparam logic [8:0]  c_LANE_LAST = 9'd19;      // lane is 20 px wide
    localparam logic [10:0] c_THRESH    = 11'(HIT_THRESH);
    localparam logic [9:0]  c_COUNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_lane;
    logic       r_valid;
    logic [9:0] r_count;

    logic [8:0] w_start_x;
    logic [8:0] w_end_x;
    logic [8:0] w_req_start_x;
    logic       w_start;
    logic       w_abort;
    logic       w_last_addr;

    // First column of a lane; unknown lane codes fall back to lane 2.
    function automatic logic [8:0] lane_start(input logic [2:0] lane);
        case (lane)
            3'd1:    lane_start = 9'd120;
            3'd2:    lane_start = 9'd140;
            3'd3:    lane_start = 9'd160;
            3'd4:    lane_start = 9'd180;
            default: lane_start = 9'd140;
        endcase
    endfunction

    // Column range of the latched lane, plus the start column of a new request.
    always_comb begin
        w_start_x     = lane_start(r_lane);
        w_end_x       = w_start_x + c_LANE_LAST;
        w_req_start_x = lane_start(line_id);
        w_start       = (r_state == IDLE) && check_go;
        w_abort       = ((r_state == READ) || (r_state == DRAIN)) && !check_go;
        w_last_addr   = (x == w_end_x) && (y == c_Y1);
    end

    // Scan control: address raster, read strobe and result publication.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_lane      <= 3'd0;
            rd_en       <= 1'b0;
            x           <= 9'd0;
            y           <= 8'd0;
            check_done  <= 1'b0;
            hit         <= 1'b0;
            pixel_count <= 10'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (check_go) begin
                        r_lane  <= line_id;
                        x       <= w_req_start_x;
                        y       <= c_Y0;
                        rd_en   <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: begin
                    if (!check_go) begin
                        rd_en   <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_last_addr) begin
                        rd_en   <= 1'b0;
                        r_state <= DRAIN;
                    end else if (x == w_end_x) begin
                        x <= w_start_x;
                        y <= y + 8'd1;
                    end else begin
                        x <= x + 9'd1;
                    end
                end
                DRAIN: begin
                    // The final read's data is counted on this edge.
                    r_state <= check_go ? DONE : IDLE;
                end
                DONE: begin
                    // The count is final here, so republishing it is harmless.
                    pixel_count <= r_count;
                    hit         <= ({1'b0, r_count} >= c_THRESH);
                    check_done  <= check_go;
                    r_state     <= check_go ? DONE : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read-data pipeline: delay the strobe one cycle and count tile-coloured pixels.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_count <= 10'd0;
        end else begin
            r_valid <= w_abort ? 1'b0 : rd_en;
            if (w_start) begin
                r_count <= 10'd0;
            end else if (r_valid && (rd_data == TILE_COLOUR) && (r_count != c_COUNT_MAX)) begin
                r_count <= r_count + 10'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_hit_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lane_hit_reader
//  Description : Directed self-checking bench for lane_hit_reader with a
//                synchronous-read framebuffer model and a read-address monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_hit_reader;

    logic       clock;
    logic       resetn;
    logic       check_go;
    logic [2:0] line_id;
    logic       rd_en;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] rd_data;
    logic       check_done;
    logic       hit;
    logic [9:0] pixel_count;

    int errors;
    int checks;

    // Framebuffer pattern select:
    // 0 = tile everywhere, 1 = tile rows<=219, 2 = tile rows<=218, 3 = tile cols 140..159
    int mem_mode;

    // Monitor statistics
    logic mon_clr;
    int   n_reads;
    int   first_x, first_y, last_x, last_y, min_x, max_x;

    lane_hit_reader dut (
        .clock       (clock),
        .resetn      (resetn),
        .check_go    (check_go),
        .line_id     (line_id),
        .rd_en       (rd_en),
        .x           (x),
        .y           (y),
        .rd_data     (rd_data),
        .check_done  (check_done),
        .hit         (hit),
        .pixel_count (pixel_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] pixel(input int px, input int py);
        logic tile;
        case (mem_mode)
            0:       tile = 1'b1;
            1:       tile = (py <= 219);
            2:       tile = (py <= 218);
            default: tile = (px >= 140) && (px <= 159);
        endcase
        pixel = tile ? 3'b000 : 3'b111;
    endfunction

    // Synchronous-read framebuffer.
    always @(posedge clock) begin
        if (rd_en) rd_data <= pixel(int'(x), int'(y));
    end

    // Record every issued read address.
    always @(posedge clock) begin
        if (mon_clr) begin
            n_reads = 0;
            min_x   = 999;
            max_x   = -1;
        end else if (rd_en) begin
            if (n_reads == 0) begin
                first_x = int'(x);
                first_y = int'(y);
            end
            last_x = int'(x);
            last_y = int'(y);
            if (int'(x) < min_x) min_x = int'(x);
            if (int'(x) > max_x) max_x = int'(x);
            n_reads = n_reads + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raise check_go for a lane and wait for check_done; returns latency in cycles.
    task automatic start_scan(input logic [2:0] lane, input int mode, output int lat);
        @(negedge clock);
        mem_mode = mode;
        mon_clr  = 1'b1;
        @(negedge clock);
        mon_clr  = 1'b0;
        line_id  = lane;
        check_go = 1'b1;
        lat = 0;
        while (1) begin
            @(posedge clock);
            #1;
            lat = lat + 1;
            if (check_done) break;
            if (lat > 2000) begin
                check_val("done_timeout", 32'(lat), 32'd803);
                break;
            end
        end
    endtask

    // Drop check_go and confirm check_done falls.
    task automatic end_scan();
        @(negedge clock);
        check_go = 1'b0;
        @(posedge clock);
        #1;
        check_val("done_fall", 32'(check_done), 32'd0);
    endtask

    int lat;
    int seen_done;

    initial begin
        errors   = 0;
        checks   = 0;
        mem_mode = 0;
        mon_clr  = 1'b1;
        check_go = 1'b0;
        line_id  = 3'd0;
        resetn   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_rd_en", 32'(rd_en), 32'd0);
        check_val("rst_x", 32'(x), 32'd0);
        check_val("rst_y", 32'(y), 32'd0);
        check_val("rst_done", 32'(check_done), 32'd0);
        check_val("rst_hit", 32'(hit), 32'd0);
        check_val("rst_count", 32'(pixel_count), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Lane 3, full tile: 800 reads from (160,200) to (179,239).
        start_scan(3'd3, 0, lat);
        check_val("l3_latency", 32'(lat), 32'd803);
        check_val("l3_count", 32'(pixel_count), 32'd800);
        check_val("l3_hit", 32'(hit), 32'd1);
        check_val("l3_nreads", 32'(n_reads), 32'd800);
        check_val("l3_first_x", 32'(first_x), 32'd160);
        check_val("l3_first_y", 32'(first_y), 32'd200);
        check_val("l3_last_x", 32'(last_x), 32'd179);
        check_val("l3_last_y", 32'(last_y), 32'd239);
        end_scan();

        // Lane 1 at the threshold boundary.
        start_scan(3'd1, 1, lat);
        check_val("l1_400_count", 32'(pixel_count), 32'd400);
        check_val("l1_400_hit", 32'(hit), 32'd1);
        check_val("l1_first_x", 32'(first_x), 32'd120);
        end_scan();
        start_scan(3'd1, 2, lat);
        check_val("l1_380_count", 32'(pixel_count), 32'd380);
        check_val("l1_380_hit", 32'(hit), 32'd0);
        end_scan();

        // Abort during READ: previous result (380, miss) must stay.
        @(negedge clock);
        mem_mode = 0;
        line_id  = 3'd3;
        check_go = 1'b1;
        repeat (300) @(posedge clock);
        @(negedge clock);
        check_go = 1'b0;
        line_id  = 3'd4;
        @(posedge clock);
        #1;
        check_val("abort_rd_en", 32'(rd_en), 32'd0);
        seen_done = 0;
        repeat (1000) begin
            @(posedge clock);
            #1;
            if (check_done) seen_done = 1;
        end
        check_val("abort_no_done", 32'(seen_done), 32'd0);
        check_val("abort_count", 32'(pixel_count), 32'd380);
        check_val("abort_hit", 32'(hit), 32'd0);

        // Unknown lane code decodes to lane 2.
        start_scan(3'b111, 3, lat);
        check_val("def_count", 32'(pixel_count), 32'd800);
        check_val("def_min_x", 32'(min_x), 32'd140);
        check_val("def_max_x", 32'(max_x), 32'd159);
        check_val("def_nreads", 32'(n_reads), 32'd800);

        // Back-to-back: hold through DONE, drop one cycle, re-raise.
        repeat (5) @(posedge clock);
        #1;
        check_val("b2b_hold_done", 32'(check_done), 32'd1);
        end_scan();
        start_scan(3'd3, 1, lat);
        check_val("b2b_latency", 32'(lat), 32'd803);
        check_val("b2b_first_x", 32'(first_x), 32'd160);
        check_val("b2b_first_y", 32'(first_y), 32'd200);
        check_val("b2b_count", 32'(pixel_count), 32'd400);
        check_val("b2b_hit", 32'(hit), 32'd1);

        // Reset mid-READ.
        end_scan();
        @(negedge clock);
        mem_mode = 0;
        line_id  = 3'd2;
        check_go = 1'b1;
        repeat (100) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check_val("mrst_rd_en", 32'(rd_en), 32'd0);
        check_val("mrst_x", 32'(x), 32'd0);
        check_val("mrst_y", 32'(y), 32'd0);
        check_val("mrst_done", 32'(check_done), 32'd0);
        check_val("mrst_hit", 32'(hit), 32'd0);
        check_val("mrst_count", 32'(pixel_count), 32'd0);
        check_go = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        start_scan(3'd4, 0, lat);
        check_val("post_rst_latency", 32'(lat), 32'd803);
        check_val("post_rst_count", 32'(pixel_count), 32'd800);
        check_val("post_rst_first_x", 32'(first_x), 32'd180);
        check_val("post_rst_last_x", 32'(last_x), 32'd199);
        end_scan();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_hit_reader.md
Name: lane_hit_reader

Overview:
- Read-side counterpart of the lane/block pixel writers.
- On request, scans one lane's hit zone in the framebuffer through a synchronous-read port.
- Counts pixels matching the tile colour and reports hit/miss with a go/done handshake.
- Sits between the game FSM, which issues check requests, and the framebuffer read port.

Parameters:
- ZONE_Y0, 200, first row of the hit zone (inclusive).
- ZONE_Y1, 239, last row of the hit zone (inclusive).
- TILE_COLOUR, 3'b000, colour value counted as tile.
- HIT_THRESH, 400, minimum matching-pixel count for hit=1.

Ports:
- clock  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- check_go  input  1  level request; held high until check_done is seen.
- line_id  input  3  lane select: 1..4; any other value maps to lane 2.
- rd_en  output  1  framebuffer read strobe.
- x  output  9  framebuffer read column.
- y  output  8  framebuffer read row.
- rd_data  input  3  framebuffer colour; valid the cycle after rd_en.
- check_done  output  1  result valid; held until check_go low.
- hit  output  1  1 when pixel_count >= HIT_THRESH.
- pixel_count  output  10  matching pixels counted in the last completed scan.

Behaviour:
- Lane decode (combinational from the latched lane), start_x..end_x:
  - 1 -> 120..139
  - 2 -> 140..159
  - 3 -> 160..179
  - 4 -> 180..199
  - default -> 140..159
- Lane is 20 px wide; with the defaults the zone is 40 rows, 800 pixels.
- Reset (async, resetn=0): state=IDLE, rd_en=0, x=0, y=0, check_done=0, hit=0, pixel_count=0, internal count=0, pipeline valid=0.
- States:
  - IDLE: when check_go=1, latch line_id, set x=start_x, y=ZONE_Y0, clear internal count, go to READ. Otherwise outputs hold.
  - READ: rd_en=1 every cycle. Raster x from start_x to end_x; at end_x, wrap x to start_x and increment y. After issuing address (end_x, ZONE_Y1), go to DRAIN. Exactly 800 reads with the defaults, no gaps.
  - DRAIN: rd_en=0; one cycle to capture the last read's data. Then go to DONE.
  - DONE: pixel_count=internal count; hit=(count >= HIT_THRESH); check_done=1. Stay in DONE while check_go=1. When check_go=0, go to IDLE and clear check_done the next cycle. hit and pixel_count hold until the next completed scan.
- Data pipeline: a 1-bit valid register delays rd_en by one cycle.
  - When valid=1 and rd_data==TILE_COLOUR, internal count increments by 1.
  - Count saturates at 1023; unreachable with the defaults.
- Latency: check_go rise -> check_done=1 in 1 (IDLE) + 800 (READ) + 1 (DRAIN) + 1 (DONE register) = 803 cycles with the defaults.
- Abort: check_go=0 while in READ or DRAIN -> go to IDLE next cycle.
  - rd_en=0, check_done stays 0.
  - hit and pixel_count keep their previous values.
  - In-flight read data is discarded: valid cleared, count not committed.
- line_id changes during a scan are ignored; only the value latched in IDLE is used.
- check_go already high on exit from DONE is not possible, since exit requires check_go=0. A new request needs a low-then-high on check_go.
- Reset mid-scan: immediate return to reset values, no partial result published.
- rd_data is ignored whenever valid=0.

Test Plan:
- Lane 3, memory all TILE_COLOUR in rows 200..239 -> first read address (160,200), last read (179,239); check_done at cycle 803; pixel_count=800, hit=1.
- Lane 1, only rows 200..219 tile colour, rest 3'b111 -> pixel_count=400, hit=1 (threshold boundary). Repeat with rows 200..218 -> pixel_count=380, hit=0.
- line_id=3'b111, memory tile only in columns 140..159 -> reads in x 140..159 only; pixel_count=800.
- check_go dropped at cycle 300 of READ -> rd_en=0 next cycle, check_done never rises; hit and pixel_count equal the previous scan's values.
- Back-to-back requests: hold check_go through DONE, then drop for 1 cycle and re-raise -> check_done falls, second scan starts from (start_x,200) with the count cleared.
- resetn pulsed low mid-READ -> all outputs go to reset values asynchronously; after release, a new check_go gives a full scan with a correct count.
